// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared FSM encoding and counter width for the DDR TX serializer
package io_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_TRAIL = 2'd3;

    // LEAD/TRAIL phase counter width; covers LEAD_CYCLES/TRAIL_CYCLES up to 15.
    localparam int PHASE_W = 4;

endpackage

// File: rtl/io_ddr_tx_serializer.sv
// rtl/io_ddr_tx_serializer.sv - word-to-DDR-bit-pair serializer driving an IO cell
//
// Ports:
//   OUTPUTCLK     in   clock (rising edge), also routed to the IO cell
//   RESET         in   synchronous active-high reset
//   IN_VALID      in   IN_DATA holds a word to send
//   IN_DATA       in   word to send, LSB first, two bits per beat
//   IN_READY      out  word accepted on this edge if IN_VALID is high
//   DOUT0         out  rising-edge bit (even bit of the word)
//   DOUT1         out  falling-edge bit (odd bit of the word)
//   OUTPUTENABLE  out  pad drive enable
//   BUSY          out  FSM is not idle
//   TX_DONE       out  one-cycle pulse on the first idle cycle after a burst
module io_ddr_tx_serializer
    import io_pkg::*;
#(
    parameter int   WORD_W       = 8,
    parameter int   LEAD_CYCLES  = 1,
    parameter int   TRAIL_CYCLES = 1,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic              OUTPUTCLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    input  logic [WORD_W-1:0] IN_DATA,
    output logic              IN_READY,
    output logic              DOUT0,
    output logic              DOUT1,
    output logic              OUTPUTENABLE,
    output logic              BUSY,
    output logic              TX_DONE
);

    localparam int BEATS  = WORD_W / 2;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [PHASE_W-1:0] LEAD_LAST  = PHASE_W'(LEAD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] TRAIL_LAST = PHASE_W'(TRAIL_CYCLES - 1);

    logic [1:0]         state;
    logic [BEAT_W-1:0]  beat;
    logic [PHASE_W-1:0] phase;
    logic [WORD_W-1:0]  shreg;

    logic last_beat;
    logic xfer;

    assign last_beat = (beat == BEAT_LAST);
    assign IN_READY  = (state == ST_IDLE) || ((state == ST_SHIFT) && last_beat);
    assign BUSY      = (state != ST_IDLE);
    assign xfer      = IN_VALID && IN_READY;

    always_ff @(posedge OUTPUTCLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            beat         <= '0;
            phase        <= '0;
            shreg        <= '0;
            DOUT0        <= IDLE_LEVEL;
            DOUT1        <= IDLE_LEVEL;
            OUTPUTENABLE <= 1'b0;
            TX_DONE      <= 1'b0;
        end else begin
            // Pad outputs are a registered image of the current state, so they
            // trail the FSM by one cycle; the shift register's low pair is the
            // bit pair of the current beat.
            OUTPUTENABLE <= (state != ST_IDLE);
            DOUT0        <= (state == ST_SHIFT) ? shreg[0] : IDLE_LEVEL;
            DOUT1        <= (state == ST_SHIFT) ? shreg[1] : IDLE_LEVEL;
            TX_DONE      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        shreg <= IN_DATA;
                        beat  <= '0;
                        phase <= '0;
                        state <= (LEAD_CYCLES > 0) ? ST_LEAD : ST_SHIFT;
                    end
                end
                ST_LEAD: begin
                    if (phase == LEAD_LAST) begin
                        phase <= '0;
                        beat  <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                ST_SHIFT: begin
                    if (last_beat) begin
                        beat <= '0;
                        if (xfer) begin
                            // Reload in place: next word's beat 0 follows directly.
                            shreg <= IN_DATA;
                        end else if (TRAIL_CYCLES > 0) begin
                            phase <= '0;
                            state <= ST_TRAIL;
                        end else begin
                            phase   <= '0;
                            state   <= ST_IDLE;
                            TX_DONE <= 1'b1;
                        end
                    end else begin
                        shreg <= shreg >> 2;
                        beat  <= beat + BEAT_W'(1);
                    end
                end
                ST_TRAIL: begin
                    if (phase == TRAIL_LAST) begin
                        phase   <= '0;
                        state   <= ST_IDLE;
                        TX_DONE <= 1'b1;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                default: begin
                    phase <= '0;
                    beat  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/io_ddr_tx_serializer.md
IO_DDR_TX_SERIALIZER -- requirements
Module: io_ddr_tx_serializer

Interface
REQ-001 Parameter WORD_W, default 8, word width in bits; SHALL be even and at least 2.
REQ-002 Parameter LEAD_CYCLES, default 1, number of cycles OUTPUTENABLE is high before the first data pair; range 0..15.
REQ-003 Parameter TRAIL_CYCLES, default 1, number of cycles OUTPUTENABLE stays high after the last data pair; range 0..15.
REQ-004 Parameter IDLE_LEVEL, default 1'b1, level driven on DOUT0/DOUT1 when no data bit is being sent.
REQ-005 OUTPUTCLK  input  1  sole clock, rising edge; also feeds the downstream IO cell OUTPUTCLK.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 IN_VALID  input  1  IN_DATA holds a word to send.
REQ-008 IN_DATA  input  WORD_W  word to serialize, LSB first.
REQ-009 IN_READY  output  1  block accepts IN_DATA this cycle.
REQ-010 DOUT0  output  1  rising-edge bit to the IO cell DOUT0.
REQ-011 DOUT1  output  1  falling-edge bit to the IO cell DOUT1.
REQ-012 OUTPUTENABLE  output  1  pad drive enable to the IO cell.
REQ-013 BUSY  output  1  high whenever state is not IDLE.
REQ-014 TX_DONE  output  1  one-cycle pulse when a burst ends (entry to IDLE from SHIFT or TRAIL).

Function
REQ-015 A word SHALL be transferred on any rising edge where IN_VALID and IN_READY are both high.
REQ-016 IN_READY SHALL depend only on state and beat counter: high in IDLE, high in SHIFT on the last beat, low otherwise.
REQ-017 FSM states SHALL be IDLE, LEAD, SHIFT, TRAIL.
REQ-018 IDLE: on transfer, go to LEAD if LEAD_CYCLES>0, else to SHIFT; otherwise stay.
REQ-019 LEAD: OUTPUTENABLE=1, DOUT0=DOUT1=IDLE_LEVEL for exactly LEAD_CYCLES cycles, then SHIFT.
REQ-020 SHIFT: beat k (0..WORD_W/2-1) SHALL drive DOUT0=word[2k], DOUT1=word[2k+1], OUTPUTENABLE=1; one beat per cycle.
REQ-021 On the last beat, transfer SHALL reload the shift register so the next word's beat 0 follows with no gap; without a transfer, go to TRAIL if TRAIL_CYCLES>0, else IDLE.
REQ-022 TRAIL: OUTPUTENABLE=1, DOUT=IDLE_LEVEL for exactly TRAIL_CYCLES cycles, then IDLE; IN_VALID arriving during TRAIL SHALL wait until IDLE.
REQ-023 IDLE: OUTPUTENABLE=0, DOUT0=DOUT1=IDLE_LEVEL.
REQ-024 DOUT0, DOUT1, OUTPUTENABLE SHALL be registered; with LEAD_CYCLES=0, beat 0 of a word transferred on edge N SHALL appear on outputs after edge N+1.
REQ-025 The accepted word SHALL be captured on transfer; IN_DATA changes after transfer SHALL not affect output.
REQ-026 Beat counter SHALL be ceil(log2(WORD_W/2)) bits minimum and SHALL wrap to 0 on reload.
REQ-027 LEAD/TRAIL counter SHALL be 4 bits and SHALL be cleared on every state entry.
REQ-028 TX_DONE SHALL be registered and coincide with the first IDLE cycle.

Reset
REQ-029 While RESET is high at an edge: state=IDLE, counters=0, shift register=0, IN_READY=1 after reset, OUTPUTENABLE=0, DOUT0=DOUT1=IDLE_LEVEL, BUSY=0, TX_DONE=0.
REQ-030 RESET asserted mid-burst SHALL abort it: the in-flight word is discarded, no TX_DONE pulse, OUTPUTENABLE low on the cycle after the reset edge.
REQ-031 RESET SHALL take priority over a simultaneous transfer; the word is dropped.

Structure
REQ-032 State encoding enum and LEAD/TRAIL counter width constant SHALL live in shared package io_pkg.
REQ-033 Single module, no sub-modules; FSM, counters and shift register are inline.

Verification
REQ-034 WORD_W=8, LEAD=1, TRAIL=1, single word 0xA5: OE high 6 cycles; pairs (DOUT0,DOUT1)=(1,0),(1,0),(0,1),(0,1) across beats 0-3; TX_DONE once.
REQ-035 Back-to-back 0x0F then 0xF0 with IN_VALID held: 8 contiguous beats, no idle cycle between words, IN_READY high only on beat 3 and in IDLE.
REQ-036 LEAD=0, TRAIL=0, word 0xFF: OE high exactly 4 cycles, first beat one cycle after transfer, TX_DONE on the following cycle.
REQ-037 RESET pulsed during beat 2 of 0x3C: next cycle OE=0, DOUT=IDLE_LEVEL, BUSY=0, no TX_DONE.
REQ-038 IN_VALID raised during TRAIL with word 0x81: IN_READY low until IDLE, then new LEAD phase starts; 0x81 serialized intact.
